// File: rtl/seg7_scan_250hz.sv
// Multiplexed 7-segment scanner: advances one digit per synchronised clk_250hz edge, with an anti-ghosting blank gap.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading-zero glyphs.
module seg7_scan_250hz #(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk_50mhz,
    input  logic                  rst,
    input  logic                  clk_250hz,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an_n,
    output logic [7:0]            seg_n,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BLANK_CYCLES);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [4*DIGITS-1:0]   shad_val, shad_val_nxt;
    logic [DIGITS-1:0]     shad_dp, shad_dp_nxt;
    logic                  sync1, sync2, sync3;
    logic                  tick, snap;
    logic [3:0]            nib;
    logic [6:0]            glyph;
    logic [7:0]            seg_drive;
    logic [DIGITS-1:0]     an_drive;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // clk_250hz is sampled as data: two sync flops plus a history flop for edge detection
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk_250hz;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state    <= ST_BLANK;
            cnt      <= '0;
            idx      <= LAST_IDX;
            shad_val <= '0;
            shad_dp  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shad_val <= shad_val_nxt;
            shad_dp  <= shad_dp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        shad_val_nxt = shad_val;
        shad_dp_nxt  = shad_dp;
        snap         = 1'b0;
        if (tick) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (idx == LAST_IDX) begin
                snap         = 1'b1;
                shad_val_nxt = value;
                shad_dp_nxt  = dp;
            end
            if (BLANK_CYCLES > 0) begin
                state_nxt = ST_BLANK;
                cnt_nxt   = GAP_LOAD;
            end else begin
                state_nxt = ST_DRIVE;
            end
        end else if (state == ST_BLANK) begin
            // a zero count is the post-reset idle: stay dark until the first tick
            if (cnt == CNT_W'(1)) begin
                state_nxt = ST_DRIVE;
                cnt_nxt   = '0;
            end else if (cnt > CNT_W'(1)) begin
                cnt_nxt = cnt - 1'b1;
            end
        end
    end

    always_comb begin
        nib   = shad_val_nxt[{idx_nxt, 2'b00} +: 4];
        glyph = hex7(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((idx_nxt != '0) && ((shad_val_nxt >> {idx_nxt, 2'b00}) == '0))
            glyph = 7'h00;
`endif
        seg_drive = {~shad_dp_nxt[idx_nxt], ~glyph};
        an_drive  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt);
    end

    // Outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            an_n       <= '1;
            seg_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= snap;
            if (state_nxt == ST_DRIVE) begin
                an_n  <= an_drive;
                seg_n <= seg_drive;
            end else begin
                an_n  <= '1;
                seg_n <= '1;
            end
        end
    end

endmodule
